mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the core's single synchronous memory port between instruction fetch (IF) and the load/store stage (LS). It grants at most one request per cycle and gives LS priority, with a starvation guard for IF. It tracks in-flight reads in a LOAD_LATENCY-deep owner pipeline so each read response is routed back to its requester. It also produces the per-requester stall signals that feed the pipeline stall logic alongside the load-use interlock.

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, data width
- LOAD_LATENCY, 1, memory read latency in cycles (≥1)
- STARVE_LIMIT, 4, consecutive denied IF cycles before IF is forced ahead of LS (≥1)

- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch read request; held with stable if_addr until granted
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  discard all in-flight fetch responses
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- ls_req  in  1  load/store request; held with stable fields until granted
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  load/store address
- ls_wdata  in  DATA_W  store data
- ls_gnt  out  1  load/store request accepted this cycle
- ls_rvalid  out  1  load data valid
- ls_rdata  out  DATA_W  load data
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid LOAD_LATENCY cycles after the read's mem_en
- stall_if  out  1  if_req & ~if_gnt
- stall_ls  out  1  ls_req & ~ls_gnt

## Operation
- Grant is combinational in the request cycle.
  - Only one requester active: it is granted.
  - Both active: LS wins, unless starve_cnt == STARVE_LIMIT, in which case IF wins.
- mem_en = if_gnt | ls_gnt.
  - mem_we, mem_addr and mem_wdata come from the winner.
  - mem_we = 0 and mem_wdata = 0 when IF wins.
  - All mem_* outputs are 0 when idle.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, each cycle with if_req & ~if_gnt.
  - Clears to 0 on if_gnt or when if_req is low.
- Owner pipeline: LOAD_LATENCY stages of {valid, owner}.
  - Stage 0 is loaded with valid = granted read (not store) and owner = IF/LS.
  - The pipeline shifts every cycle, with no back-pressure.
- Response routing from the last stage:
  - valid & owner = IF gives if_rvalid.
  - valid & owner = LS gives ls_rvalid.
  - if_rdata and ls_rdata both equal mem_rdata unconditionally; consumers qualify with rvalid.
- Stores produce no rvalid; ls_gnt is the completion.
- if_flush:
  - Clears valid on every IF-owned stage at the edge.
  - Forces if_rvalid = 0 combinationally in the same cycle.
  - Does not block a new if_gnt in that cycle; that new read is kept.
- LS entries are never flushed.

## Timing
- Throughput is one access per cycle.
- A read granted in cycle t gives rvalid in cycle t+LOAD_LATENCY.
- Grant, stall and mem_* outputs have zero latency from req.
- Reset state:
  - All owner stages invalid; starve_cnt = 0.
  - All rvalid = 0; stall_* = 0 while no req.
- Reset mid-operation: in-flight reads are dropped and no rvalid is produced for them after rstn rises.
- Simultaneous flush and IF response: the response is suppressed.
- Simultaneous flush and LS response: the LS response is delivered.
- STARVE_LIMIT boundary: with both reqs held continuously, LS is granted STARVE_LIMIT times, then IF once; the pattern then repeats.

## Configuration
- MEM_ARB_PERF_EN defined: adds outputs perf_conflict (32-bit) and perf_forced (32-bit).
  - perf_conflict counts cycles with if_req & ls_req.
  - perf_forced counts IF grants caused by the starvation guard.
  - Both counters saturate at 2^32-1 and reset to 0.
- MEM_ARB_PERF_EN undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Test plan
- IF-only: if_req with addr 0x100 for 1 cycle, LOAD_LATENCY = 1 → if_gnt = 1 and mem_en = 1 at t; if_rvalid = 1 at t+1 with mem_rdata passed through.
- Conflict: if_req and ls_req (load at 0x200) both held, STARVE_LIMIT = 4 → ls_gnt for 4 cycles with stall_if = 1, then if_gnt in cycle 5, then ls_gnt again.
- Store: ls_we = 1, addr 0x40, wdata 0xDEAD → mem_we = 1 and mem_wdata = 0xDEAD at t; no ls_rvalid at t+LOAD_LATENCY.
- Flush: LOAD_LATENCY = 3, fetch reads granted at t and t+1, a load granted at t+2, if_flush at t+2 → no if_rvalid at t+3 or t+4; ls_rvalid at t+5.
- Reset: rstn low one cycle after a read grant → no rvalid afterwards; all outputs 0 while in reset.
- Perf (MEM_ARB_PERF_EN): 10 cycles of both reqs, STARVE_LIMIT = 4 → perf_conflict = 10, perf_forced = 2.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one synchronous memory port between fetch (IF) and
//            load/store (LS). LS has priority, IF has a starvation guard,
//            and read responses are routed back through an owner pipeline.
//            Optional perf counters are built when MEM_ARB_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 64,
   parameter int LOAD_LATENCY = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_ls
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]       perf_conflict,
   output logic [31:0]       perf_forced
`endif
);

   localparam int                 c_cnt_w      = $clog2(STARVE_LIMIT + 1);
   localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_LIMIT);

   logic [c_cnt_w-1:0]      r_starve_cnt;
   logic                    w_force_if;
   logic                    w_if_gnt;
   logic                    w_ls_gnt;
   logic                    w_rd_gnt;
   logic [LOAD_LATENCY-1:0] r_valid;
   logic [LOAD_LATENCY-1:0] r_owner_ls;
   logic [LOAD_LATENCY-1:0] w_nxt_valid;
   logic [LOAD_LATENCY-1:0] w_nxt_owner;
   logic                    w_resp_v;
   logic                    w_resp_ls;

   // IF overtakes LS only once it has been denied STARVE_LIMIT cycles in a row
   assign w_force_if = (r_starve_cnt == c_starve_max);
   assign w_if_gnt   = if_req & (~ls_req | w_force_if);
   assign w_ls_gnt   = ls_req & ~w_if_gnt;
   assign w_rd_gnt   = w_if_gnt | (w_ls_gnt & ~ls_we);

   assign if_gnt   = w_if_gnt;
   assign ls_gnt   = w_ls_gnt;
   assign stall_if = if_req & ~w_if_gnt;
   assign stall_ls = ls_req & ~w_ls_gnt;

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_ls_gnt) begin
         mem_en    = 1'b1;
         mem_we    = ls_we;
         mem_addr  = ls_addr;
         mem_wdata = ls_wdata;
      end else if (w_if_gnt) begin
         mem_en   = 1'b1;
         mem_addr = if_addr;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_starve_cnt <= '0;
      end else if (if_req & ~w_if_gnt) begin
         if (r_starve_cnt != c_starve_max) begin
            r_starve_cnt <= r_starve_cnt + c_cnt_w'(1);
         end
      end else begin
         r_starve_cnt <= '0;
      end
   end

   // Stage 0 always takes this cycle's grant; a flush only hits older entries
   assign w_nxt_valid[0] = w_rd_gnt;
   assign w_nxt_owner[0] = w_ls_gnt;

   for (genvar gi = 1; gi < LOAD_LATENCY; gi++) begin : g_stage
      assign w_nxt_valid[gi] = r_valid[gi-1] & ~(if_flush & ~r_owner_ls[gi-1]);
      assign w_nxt_owner[gi] = r_owner_ls[gi-1];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_valid    <= '0;
         r_owner_ls <= '0;
      end else begin
         r_valid    <= w_nxt_valid;
         r_owner_ls <= w_nxt_owner;
      end
   end

   assign w_resp_v  = r_valid[LOAD_LATENCY-1];
   assign w_resp_ls = r_owner_ls[LOAD_LATENCY-1];
   assign if_rvalid = w_resp_v & ~w_resp_ls & ~if_flush;
   assign ls_rvalid = w_resp_v & w_resp_ls;
   assign if_rdata  = mem_rdata;
   assign ls_rdata  = mem_rdata;

`ifdef MEM_ARB_PERF_EN
   logic [31:0] r_perf_conflict;
   logic [31:0] r_perf_forced;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_perf_conflict <= '0;
         r_perf_forced   <= '0;
      end else begin
         if (if_req & ls_req & (r_perf_conflict != '1)) begin
            r_perf_conflict <= r_perf_conflict + 32'd1;
         end
         if (w_if_gnt & ls_req & w_force_if & (r_perf_forced != '1)) begin
            r_perf_forced <= r_perf_forced + 32'd1;
         end
      end
   end

   assign perf_conflict = r_perf_conflict;
   assign perf_forced   = r_perf_forced;
`else
   // Perf counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter (LOAD_LATENCY = 3,
//            STARVE_LIMIT = 4); perf ports are checked with MEM_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;
   localparam int LL     = 3;
   localparam int SL     = 4;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              if_req = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0;
   logic              if_flush = 1'b0;
   logic              if_gnt, if_rvalid, ls_gnt, ls_rvalid;
   logic [DATA_W-1:0] if_rdata, ls_rdata;
   logic              ls_req = 1'b0;
   logic              ls_we = 1'b0;
   logic [ADDR_W-1:0] ls_addr = '0;
   logic [DATA_W-1:0] ls_wdata = '0;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic              stall_if, stall_ls;
`ifdef MEM_ARB_PERF_EN
   logic [31:0]       perf_conflict, perf_forced;
`endif

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOAD_LATENCY(LL), .STARVE_LIMIT(SL)
   ) u_dut (
      .clk(clk), .rstn(rstn),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_ls(stall_ls)
`ifdef MEM_ARB_PERF_EN
      , .perf_conflict(perf_conflict), .perf_forced(perf_forced)
`endif
   );

   // Memory model: read data depends on the address, returned LL cycles later
   function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] a);
      return {a ^ 32'h5A5A_0000, ~a};
   endfunction

   logic [LL-1:0]     m_v;
   logic [ADDR_W-1:0] m_a [LL];
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_v <= '0;
      end else begin
         m_v    <= {m_v[LL-2:0], mem_en & ~mem_we};
         m_a[0] <= mem_addr;
         for (int k = 1; k < LL; k++) m_a[k] <= m_a[k-1];
      end
   end
   assign mem_rdata = m_v[LL-1] ? rd_data(m_a[LL-1]) : '0;

   typedef struct {
      int              due;
      bit              ls;
      logic [DATA_W-1:0] data;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      logic ir; logic [ADDR_W-1:0] ia;
      logic lr; logic lw; logic [ADDR_W-1:0] la; logic [DATA_W-1:0] lwd;
      logic fl; logic eig; logic elg;
   } vec_t;
   vec_t vecs[$];

   int cyc    = 0;
   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " if_gnt"},    if_gnt,    0);
      chk({tag, " ls_gnt"},    ls_gnt,    0);
      chk({tag, " mem_en"},    mem_en,    0);
      chk({tag, " mem_we"},    mem_we,    0);
      chk({tag, " mem_addr"},  mem_addr,  0);
      chk({tag, " mem_wdata"}, mem_wdata, 0);
      chk({tag, " if_rvalid"}, if_rvalid, 0);
      chk({tag, " ls_rvalid"}, ls_rvalid, 0);
      chk({tag, " stall_if"},  stall_if,  0);
      chk({tag, " stall_ls"},  stall_ls,  0);
   endtask

   task automatic step(input logic ir, input logic [ADDR_W-1:0] ia, input logic lr,
                       input logic lw, input logic [ADDR_W-1:0] la,
                       input logic [DATA_W-1:0] lwd, input logic fl,
                       input logic eig, input logic elg, input string tag);
      logic              e_en, e_we, e_iv, e_lv;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_wd, e_d;
      sb_t               e;
      if_req = ir; if_addr = ia; ls_req = lr; ls_we = lw;
      ls_addr = la; ls_wdata = lwd; if_flush = fl;
      @(negedge clk);
      e_en = eig | elg;
      e_we = elg & lw;
      e_addr = elg ? la : (eig ? ia : '0);
      e_wd   = elg ? lwd : '0;
      chk({tag, " if_gnt"},    if_gnt,    eig);
      chk({tag, " ls_gnt"},    ls_gnt,    elg);
      chk({tag, " stall_if"},  stall_if,  ir & ~eig);
      chk({tag, " stall_ls"},  stall_ls,  lr & ~elg);
      chk({tag, " mem_en"},    mem_en,    e_en);
      chk({tag, " mem_we"},    mem_we,    e_we);
      chk({tag, " mem_addr"},  mem_addr,  e_addr);
      chk({tag, " mem_wdata"}, mem_wdata, e_wd);
      if (fl) begin
         for (int k = sb_q.size() - 1; k >= 0; k--) if (!sb_q[k].ls) sb_q.delete(k);
      end
      e_iv = 1'b0; e_lv = 1'b0; e_d = '0;
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
         e = sb_q.pop_front();
         e_iv = !e.ls; e_lv = e.ls; e_d = e.data;
      end
      chk({tag, " if_rvalid"}, if_rvalid, e_iv);
      chk({tag, " ls_rvalid"}, ls_rvalid, e_lv);
      if (e_iv) chk({tag, " if_rdata"}, if_rdata, e_d);
      if (e_lv) chk({tag, " ls_rdata"}, ls_rdata, e_d);
      if (eig) sb_q.push_back('{due: cyc + LL, ls: 1'b0, data: rd_data(ia)});
      else if (elg && !lw) sb_q.push_back('{due: cyc + LL, ls: 1'b1, data: rd_data(la)});
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, '0, 0, 0, '0, '0, 0, 0, 0, "idle");
   endtask

   task automatic reset_cycle();
      rstn = 1'b0; if_req = 0; ls_req = 0; ls_we = 0; if_flush = 0;
      if_addr = '0; ls_addr = '0; ls_wdata = '0;
      @(negedge clk);
      chk_idle("reset");
      @(posedge clk); #1;
      rstn = 1'b1;
      cyc++;
      sb_q.delete();
   endtask

   function automatic vec_t v(input logic ir, input logic [ADDR_W-1:0] ia, input logic lr,
                              input logic lw, input logic [ADDR_W-1:0] la,
                              input logic [DATA_W-1:0] lwd, input logic eig, input logic elg);
      vec_t r;
      r.ir = ir; r.ia = ia; r.lr = lr; r.lw = lw; r.la = la; r.lwd = lwd;
      r.fl = 1'b0; r.eig = eig; r.elg = elg;
      return r;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Table: grants, mem mux and starvation with both requests held
      vecs.push_back(v(0, 'h000, 0, 0, 'h000, 'h0,    0, 0));
      vecs.push_back(v(1, 'h100, 0, 0, 'h000, 'h0,    1, 0));
      vecs.push_back(v(0, 'h000, 1, 0, 'h200, 'h0,    0, 1));
      vecs.push_back(v(0, 'h000, 1, 1, 'h040, 'hDEAD, 0, 1));
      vecs.push_back(v(0, 'h000, 0, 0, 'h000, 'h0,    0, 0));
      vecs.push_back(v(0, 'h000, 0, 0, 'h000, 'h0,    0, 0));
      for (int k = 0; k < SL; k++) vecs.push_back(v(1, 'h300, 1, 0, 'h200, 'h0, 0, 1));
      vecs.push_back(v(1, 'h300, 1, 0, 'h200, 'h0,    1, 0));
      vecs.push_back(v(1, 'h304, 1, 0, 'h204, 'h0,    0, 1));
      vecs.push_back(v(1, 'h304, 0, 0, 'h000, 'h0,    1, 0));
      vecs.push_back(v(1, 'h308, 1, 1, 'h044, 'hBEEF, 0, 1));
      vecs.push_back(v(0, 'h000, 1, 0, 'h208, 'h0,    0, 1));
      vecs.push_back(v(0, 'h000, 0, 0, 'h000, 'h0,    0, 0));
      for (int k = 0; k < 3; k++) vecs.push_back(v(1, 'h310, 1, 0, 'h210, 'h0, 0, 1));
      vecs.push_back(v(0, 'h000, 0, 0, 'h000, 'h0,    0, 0));
      for (int k = 0; k < SL; k++) vecs.push_back(v(1, 'h320, 1, 0, 'h220, 'h0, 0, 1));
      vecs.push_back(v(1, 'h320, 1, 0, 'h220, 'h0,    1, 0));

      @(negedge clk);
      chk_idle("init");
      @(posedge clk); #1;
      rstn = 1'b1;

      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i].ir, vecs[i].ia, vecs[i].lr, vecs[i].lw, vecs[i].la,
              vecs[i].lwd, vecs[i].fl, vecs[i].eig, vecs[i].elg, $sformatf("vec%0d", i));
      idle(LL + 1);

      // Flush kills two in-flight fetches; the load issued alongside survives
      step(1, 'h500, 0, 0, 'h000, 'h0, 0, 1, 0, "flA0");
      step(1, 'h504, 0, 0, 'h000, 'h0, 0, 1, 0, "flA1");
      step(0, 'h000, 1, 0, 'h600, 'h0, 1, 0, 1, "flA2");
      idle(LL);

      // Flush coincides with an LS response; a fetch granted during it is kept
      step(0, 'h000, 1, 0, 'h800, 'h0, 0, 0, 1, "flB0");
      step(1, 'h900, 0, 0, 'h000, 'h0, 0, 1, 0, "flB1");
      step(0, 'h000, 0, 0, 'h000, 'h0, 0, 0, 0, "flB2");
      step(1, 'h904, 0, 0, 'h000, 'h0, 1, 1, 0, "flB3");
      idle(LL);

      // Flush in the same cycle as the fetch response suppresses it
      step(1, 'hA00, 0, 0, 'h000, 'h0, 0, 1, 0, "flC0");
      idle(LL - 1);
      step(0, 'h000, 0, 0, 'h000, 'h0, 1, 0, 0, "flC3");
      idle(2);

      // Reset with loads in flight and a partly built starve count
      for (int k = 0; k < 3; k++) step(1, 'hB00, 1, 0, 'hC00 + 8 * k, 'h0, 0, 0, 1, "prerst");
      reset_cycle();
      idle(LL + 1);

      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < SL; k++) step(1, 'hD00, 1, 0, 'hE00, 'h0, 0, 0, 1, "postrst");
         step(1, 'hD00, 1, 0, 'hE00, 'h0, 0, 1, 0, "postrst_if");
      end
      idle(1);
`ifdef MEM_ARB_PERF_EN
      chk("perf_conflict", perf_conflict, 64'd10);
      chk("perf_forced",   perf_forced,   64'd2);
`endif
      idle(LL + 1);
      chk("sb_drained", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
